// File: rtl/imem_load_if.sv
// Bundle of signals between the boot/debug loader, imem_load_ctrl, the instruction memory
// byte-write port and the pipeline hold.
interface imem_load_if #(
   parameter int ADDR_W = 16
) ();

   logic              start;
   logic              load_valid;
   logic [15:0]       load_data;
   logic              load_last;
   logic              load_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              cpu_hold;
   logic              busy;
   logic              done;
   logic              err_overflow;
   logic [ADDR_W-1:0] words_loaded;
   logic [15:0]       checksum;

   // The loader side drives start and the word stream and observes everything else
   modport master (
      output start, load_valid, load_data, load_last,
      input  load_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done,
             err_overflow, words_loaded, checksum
   );

   // The controller side
   modport slave (
      input  start, load_valid, load_data, load_last,
      output load_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done,
             err_overflow, words_loaded, checksum
   );

endinterface

// File: rtl/imem_load_ctrl.sv
// Program-load sequencer: writes 16-bit words as big-endian byte pairs into instruction memory.
// Optional running checksum of loaded words is built when IMEM_LOAD_CHECKSUM_EN is defined.
module imem_load_ctrl #(
   parameter int DEPTH  = 100,
   parameter int ADDR_W = 16
) (
   input  logic        clk,
   input  logic        rst,
   imem_load_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE,
      ACCEPT,
      WR_HI,
      WR_LO,
      FINISH,
      ERR
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] wordCount_q, wordCount_d;
   logic [15:0]       word_q, word_d;
   logic              last_q, last_d;
   logic              memWe_q, memWe_d;
   logic [ADDR_W-1:0] memAddr_q, memAddr_d;
   logic [7:0]        memWdata_q, memWdata_d;
   logic              handshake;
   logic              overflow;
   logic              clearLoad;

   assign handshake = bus.load_valid & bus.load_ready;
   // Widened by one bit so the high-byte+1 check cannot wrap at the top of the address space
   assign overflow  = (({1'b0, ptr_q} + (ADDR_W + 1)'(1)) >= DEPTH_EXT);

   // State and datapath registers; a reset mid-load drops straight back to IDLE with no write
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         wordCount_q <= '0;
         word_q      <= '0;
         last_q      <= 1'b0;
         memWe_q     <= 1'b0;
         memAddr_q   <= '0;
         memWdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         wordCount_q <= wordCount_d;
         word_q      <= word_d;
         last_q      <= last_d;
         memWe_q     <= memWe_d;
         memAddr_q   <= memAddr_d;
         memWdata_q  <= memWdata_d;
      end
   end

   // Next-state logic; memory strobes are computed for the state being entered so that the
   // registered mem_we/mem_addr/mem_wdata line up exactly with WR_HI and WR_LO
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      wordCount_d = wordCount_q;
      word_d      = word_q;
      last_d      = last_q;
      memWe_d     = 1'b0;
      memAddr_d   = memAddr_q;
      memWdata_d  = memWdata_q;
      clearLoad   = 1'b0;

      case (state_q)
         IDLE, ERR: begin
            if (bus.start) begin
               state_d     = ACCEPT;
               ptr_d       = '0;
               wordCount_d = '0;
               clearLoad   = 1'b1;
            end
         end
         ACCEPT: begin
            if (handshake) begin
               word_d = bus.load_data;
               last_d = bus.load_last;
               if (overflow) begin
                  state_d = ERR;
               end else begin
                  state_d    = WR_HI;
                  memWe_d    = 1'b1;
                  memAddr_d  = ptr_q;
                  memWdata_d = bus.load_data[15:8];
               end
            end
         end
         WR_HI: begin
            state_d    = WR_LO;
            memWe_d    = 1'b1;
            memAddr_d  = ptr_q + ADDR_W'(1);
            memWdata_d = word_q[7:0];
         end
         WR_LO: begin
            ptr_d       = ptr_q + ADDR_W'(2);
            wordCount_d = wordCount_q + ADDR_W'(1);
            state_d     = last_q ? FINISH : ACCEPT;
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.load_ready   = (state_q == ACCEPT);
   assign bus.busy         = (state_q == ACCEPT) || (state_q == WR_HI) || (state_q == WR_LO);
   assign bus.cpu_hold     = (state_q != IDLE);
   assign bus.done         = (state_q == FINISH);
   assign bus.err_overflow = (state_q == ERR);
   assign bus.mem_we       = memWe_q;
   assign bus.mem_addr     = memAddr_q;
   assign bus.mem_wdata    = memWdata_q;
   assign bus.words_loaded = wordCount_q;

`ifdef IMEM_LOAD_CHECKSUM_EN
   logic [15:0] csum_q;

   // Wrap-around sum of every word that completes its low-byte write
   always_ff @(posedge clk) begin
      if (rst) begin
         csum_q <= 16'h0000;
      end else if (clearLoad) begin
         csum_q <= 16'h0000;
      end else if (state_q == WR_LO) begin
         csum_q <= csum_q + word_q;
      end
   end

   assign bus.checksum = csum_q;
`else
   logic unusedClear;
   assign unusedClear  = clearLoad;
   assign bus.checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: a DEPTH=100 instance for normal loads and a
// DEPTH=4 instance for overflow; byte writes are checked against a scoreboard queue.
module tb_imem_load_ctrl;

   localparam int ADDR_W  = 16;
   localparam int DEPTH_A = 100;
   localparam int DEPTH_B = 4;

   logic clk;
   logic rst;

   int checks = 0;
   int errors = 0;
   int doneCountA = 0;
   int doneCountB = 0;

   logic [23:0] qA[$];
   logic [23:0] qB[$];

   logic [15:0] ptrA;
   logic [15:0] wordsA;
   logic [15:0] csA;
   logic [15:0] prog [3];

   imem_load_if #(.ADDR_W(ADDR_W)) busA ();
   imem_load_if #(.ADDR_W(ADDR_W)) busB ();

   imem_load_ctrl #(.DEPTH(DEPTH_A), .ADDR_W(ADDR_W)) dutA (
      .clk (clk),
      .rst (rst),
      .bus (busA)
   );

   imem_load_ctrl #(.DEPTH(DEPTH_B), .ADDR_W(ADDR_W)) dutB (
      .clk (clk),
      .rst (rst),
      .bus (busB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory-port monitors: every write strobe must match the next expected {addr, byte}
   always @(negedge clk) begin
      if (busA.done === 1'b1) doneCountA++;
      if (busA.mem_we === 1'b1) begin
         checks++;
         if (qA.size() == 0) begin
            errors++;
            $display("[TB] FAIL A_unexpected_write addr=%0h data=%0h required=no write", busA.mem_addr, busA.mem_wdata);
         end else begin
            logic [23:0] exp;
            exp = qA.pop_front();
            if ({busA.mem_addr, busA.mem_wdata} !== exp) begin
               errors++;
               $display("[TB] FAIL A_write addr/data=%0h/%0h required=%0h/%0h", busA.mem_addr, busA.mem_wdata, exp[23:8], exp[7:0]);
            end
         end
         checks++;
         if (busA.load_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL A_ready_during_write load_ready=%b required=0", busA.load_ready);
         end
      end
   end

   always @(negedge clk) begin
      if (busB.done === 1'b1) doneCountB++;
      if (busB.mem_we === 1'b1) begin
         checks++;
         if (qB.size() == 0) begin
            errors++;
            $display("[TB] FAIL B_unexpected_write addr=%0h data=%0h required=no write", busB.mem_addr, busB.mem_wdata);
         end else begin
            logic [23:0] exp;
            exp = qB.pop_front();
            if ({busB.mem_addr, busB.mem_wdata} !== exp) begin
               errors++;
               $display("[TB] FAIL B_write addr/data=%0h/%0h required=%0h/%0h", busB.mem_addr, busB.mem_wdata, exp[23:8], exp[7:0]);
            end
         end
      end
   end

   function automatic logic [15:0] expChecksum(input logic [15:0] sum);
`ifdef IMEM_LOAD_CHECKSUM_EN
      return sum;
`else
      return 16'h0000 & sum;
`endif
   endfunction

   task automatic startA();
      busA.start = 1'b1;
      @(posedge clk); #1;
      busA.start = 1'b0;
      ptrA   = 16'd0;
      wordsA = 16'd0;
      csA    = 16'd0;
   endtask

   // Offers one word; with gap set, load_valid toggles every cycle until accepted
   task automatic feedWordA(input logic [15:0] w, input logic last, input bit gap);
      bit got;
      got = 1'b0;
      busA.load_valid = gap ? 1'b0 : 1'b1;
      busA.load_data  = w;
      busA.load_last  = last;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clk);
         if (busA.load_valid === 1'b1 && busA.load_ready === 1'b1) begin
            got = 1'b1;
            qA.push_back({ptrA, w[15:8]});
            qA.push_back({ptrA + 16'd1, w[7:0]});
            ptrA   = ptrA + 16'd2;
            wordsA = wordsA + 16'd1;
            csA    = csA + w;
         end
         @(posedge clk); #1;
         if (gap && !got) busA.load_valid = ~busA.load_valid;
      end
      busA.load_valid = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("[TB] FAIL A_handshake_timeout word=%0h accepted=0 required=1", w);
      end
   endtask

   task automatic waitDoneA();
      bit seen;
      int doneBefore;
      seen = 1'b0;
      doneBefore = doneCountA;
      for (int i = 0; i < 12 && !seen; i++) begin
         @(negedge clk);
         if (busA.done === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("[TB] FAIL A_done_timeout done=0 required=1");
      end else begin
         checks++;
         if (busA.words_loaded !== wordsA) begin
            errors++;
            $display("[TB] FAIL A_words_loaded got=%0d required=%0d", busA.words_loaded, wordsA);
         end
         checks++;
         if (busA.checksum !== expChecksum(csA)) begin
            errors++;
            $display("[TB] FAIL A_checksum got=%0h required=%0h", busA.checksum, expChecksum(csA));
         end
         checks++;
         if ({busA.busy, busA.cpu_hold} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL A_finish_flags busy/hold=%b%b required=01", busA.busy, busA.cpu_hold);
         end
         @(negedge clk);
         checks++;
         if ({busA.cpu_hold, busA.done} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL A_after_done hold/done=%b%b required=00", busA.cpu_hold, busA.done);
         end
      end
      @(posedge clk); #1;
      checks++;
      if (doneCountA - doneBefore != 1) begin
         errors++;
         $display("[TB] FAIL A_done_pulses got=%0d required=1", doneCountA - doneBefore);
      end
      checks++;
      if (qA.size() != 0) begin
         errors++;
         $display("[TB] FAIL A_pending_writes got=%0d required=0", qA.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if ({busA.load_ready, busA.mem_we, busA.cpu_hold, busA.busy, busA.done, busA.err_overflow} !== 6'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags got=%b required=000000",
                  {busA.load_ready, busA.mem_we, busA.cpu_hold, busA.busy, busA.done, busA.err_overflow});
      end
      checks++;
      if ({busA.mem_addr, busA.mem_wdata, busA.words_loaded, busA.checksum} !== 56'h0) begin
         errors++;
         $display("[TB] FAIL reset_data addr=%0h wdata=%0h words=%0h csum=%0h required=0",
                  busA.mem_addr, busA.mem_wdata, busA.words_loaded, busA.checksum);
      end
      checks++;
      if ({busB.cpu_hold, busB.err_overflow, busB.mem_we} !== 3'b0) begin
         errors++;
         $display("[TB] FAIL reset_B got=%b required=000", {busB.cpu_hold, busB.err_overflow, busB.mem_we});
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      $display("[TB] back-to-back load of three words");
      startA();
      for (int k = 0; k < 3; k++) feedWordA(prog[k], (k == 2), 1'b0);
      waitDoneA();
   endtask

   task automatic test_toggle();
      $display("[TB] load with toggling load_valid");
      startA();
      for (int k = 0; k < 3; k++) feedWordA(prog[k], (k == 2), 1'b1);
      waitDoneA();
   endtask

   task automatic test_start_in_wr_lo();
      $display("[TB] start pulsed during WR_LO");
      startA();
      feedWordA(16'h1234, 1'b0, 1'b0);
      @(posedge clk); #1;
      busA.start = 1'b1;
      @(posedge clk); #1;
      busA.start = 1'b0;
      feedWordA(16'h5678, 1'b1, 1'b0);
      waitDoneA();
   endtask

   task automatic test_start_with_valid();
      $display("[TB] start and load_valid together in IDLE");
      busA.start      = 1'b1;
      busA.load_valid = 1'b1;
      busA.load_data  = 16'hABCD;
      busA.load_last  = 1'b1;
      ptrA   = 16'd0;
      wordsA = 16'd0;
      csA    = 16'd0;
      @(negedge clk);
      checks++;
      if (busA.load_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL idle_ready got=%b required=0", busA.load_ready);
      end
      @(posedge clk); #1;
      busA.start = 1'b0;
      @(negedge clk);
      checks++;
      if (busA.load_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ready_after_start got=%b required=1", busA.load_ready);
      end else begin
         qA.push_back({ptrA, 8'hAB});
         qA.push_back({ptrA + 16'd1, 8'hCD});
         ptrA   = ptrA + 16'd2;
         wordsA = 16'd1;
         csA    = 16'hABCD;
      end
      @(posedge clk); #1;
      busA.load_valid = 1'b0;
      waitDoneA();
   endtask

   task automatic test_overflow();
      logic [15:0] ptrB;
      bit got;
      bit ovf;
      $display("[TB] overflow with DEPTH=4");
      ptrB = 16'd0;
      ovf  = 1'b0;
      busB.start = 1'b1;
      @(posedge clk); #1;
      busB.start = 1'b0;
      for (int k = 0; k < 3 && !ovf; k++) begin
         busB.load_valid = 1'b1;
         busB.load_data  = prog[k];
         busB.load_last  = (k == 2);
         got = 1'b0;
         for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (busB.load_ready === 1'b1) begin
               got = 1'b1;
               if (32'(ptrB) + 1 >= DEPTH_B) begin
                  ovf = 1'b1;
               end else begin
                  qB.push_back({ptrB, prog[k][15:8]});
                  qB.push_back({ptrB + 16'd1, prog[k][7:0]});
                  ptrB = ptrB + 16'd2;
               end
            end
            @(posedge clk); #1;
         end
         busB.load_valid = 1'b0;
         checks++;
         if (!got) begin
            errors++;
            $display("[TB] FAIL B_handshake_timeout word=%0d accepted=0 required=1", k);
         end
      end
      @(negedge clk);
      checks++;
      if ({busB.err_overflow, busB.busy, busB.cpu_hold, busB.done, busB.load_ready} !== 5'b10100) begin
         errors++;
         $display("[TB] FAIL B_err_flags err/busy/hold/done/ready=%b required=10100",
                  {busB.err_overflow, busB.busy, busB.cpu_hold, busB.done, busB.load_ready});
      end
      checks++;
      if (busB.words_loaded !== 16'(ptrB >> 1)) begin
         errors++;
         $display("[TB] FAIL B_words_loaded got=%0d required=%0d", busB.words_loaded, ptrB >> 1);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({busB.err_overflow, busB.cpu_hold} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL B_err_sticky err/hold=%b%b required=11", busB.err_overflow, busB.cpu_hold);
         end
      end
      checks++;
      if (doneCountB != 0 || qB.size() != 0) begin
         errors++;
         $display("[TB] FAIL B_done_or_pending done=%0d pending=%0d required=0/0", doneCountB, qB.size());
      end
      @(posedge clk); #1;
      busB.start = 1'b1;
      @(posedge clk); #1;
      busB.start = 1'b0;
      @(negedge clk);
      checks++;
      if ({busB.load_ready, busB.err_overflow, busB.busy, busB.words_loaded} !== {3'b101, 16'd0}) begin
         errors++;
         $display("[TB] FAIL B_restart ready/err/busy=%b words=%0d required=101 words=0",
                  {busB.load_ready, busB.err_overflow, busB.busy}, busB.words_loaded);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_write();
      $display("[TB] reset during WR_HI of second word");
      startA();
      feedWordA(16'h1120, 1'b0, 1'b0);
      feedWordA(16'h12D1, 1'b1, 1'b0);
      rst = 1'b1;
      void'(qA.pop_back());
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({busA.load_ready, busA.mem_we, busA.cpu_hold, busA.busy, busA.done, busA.err_overflow} !== 6'b0) begin
         errors++;
         $display("[TB] FAIL midreset_flags got=%b required=000000",
                  {busA.load_ready, busA.mem_we, busA.cpu_hold, busA.busy, busA.done, busA.err_overflow});
      end
      checks++;
      if ({busA.mem_addr, busA.mem_wdata, busA.words_loaded, busA.checksum} !== 56'h0) begin
         errors++;
         $display("[TB] FAIL midreset_data addr=%0h wdata=%0h words=%0h csum=%0h required=0",
                  busA.mem_addr, busA.mem_wdata, busA.words_loaded, busA.checksum);
      end
      checks++;
      if (qA.size() != 0) begin
         errors++;
         $display("[TB] FAIL midreset_pending got=%0d required=0", qA.size());
      end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      rst             = 1'b1;
      busA.start      = 1'b0;
      busA.load_valid = 1'b0;
      busA.load_data  = 16'h0000;
      busA.load_last  = 1'b0;
      busB.start      = 1'b0;
      busB.load_valid = 1'b0;
      busB.load_data  = 16'h0000;
      busB.load_last  = 1'b0;
      ptrA   = 16'd0;
      wordsA = 16'd0;
      csA    = 16'd0;
      prog[0] = 16'h1120;
      prog[1] = 16'h12D1;
      prog[2] = 16'h148E;

      test_reset();
      test_basic();
      test_toggle();
      test_start_in_wr_lo();
      test_start_with_valid();
      test_overflow();
      test_reset_mid_write();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
